// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared state encoding and LFSR constants for rng_history_core
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SHOW = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr_galois16.sv
// rtl/lfsr_galois16.sv - free-running 16-bit Galois LFSR, reloads the seed on reset
module lfsr_galois16
  import rng_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] lfsr_o
);

  // An all-zero state would lock the register, so a zero seed becomes 1.
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= SEED_NZ;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/rng_history_core.sv
// rtl/rng_history_core.sv - decelerating random roll with a ring of frozen results
// Key edges drive an IDLE/RUN/SHOW FSM; SHOW steps backwards through the history ring.
module rng_history_core
  import rng_pkg::*;
#(
  parameter int          WIDTH         = 4,
  parameter int          DEPTH         = 4,
  parameter int          STEPS         = 16,
  parameter int          BASE_INTERVAL = 4,
  parameter logic [15:0] SEED          = DEFAULT_SEED
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic                       i_show,
  output logic [WIDTH-1:0]           o_random_out,
  output logic                       o_busy,
  output logic                       o_showing,
  output logic [$clog2(DEPTH+1)-1:0] o_hist_cnt
);

  localparam int CW = $clog2(BASE_INTERVAL * STEPS + 1);
  localparam int KW = $clog2(STEPS + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int HW = $clog2(DEPTH + 1);

  logic start_prev_q, stop_prev_q, show_prev_q;
  logic start_ev, stop_ev, show_ev;

  logic [15:0]      lfsr;
  logic [WIDTH-1:0] sample;
  logic             unused_lfsr;

  state_e           state_q, state_d;
  logic [KW-1:0]    step_q, step_d;
  logic [CW-1:0]    ivl_q, ivl_d;
  logic [CW-1:0]    gap;
  logic             tick_due, run_done;
  logic [PW-1:0]    p_q, p_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    show_idx;
  logic [HW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] hist_rd;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic             busy_q, showing_q;
  logic             push;

  lfsr_galois16 #(.SEED(SEED)) u_lfsr (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .lfsr_o (lfsr)
  );

  assign sample      = lfsr[WIDTH-1:0];
  assign unused_lfsr = ^lfsr;

  assign start_ev = i_start & ~start_prev_q;
  assign stop_ev  = i_stop  & ~stop_prev_q;
  assign show_ev  = i_show  & ~show_prev_q;

  // Update k is followed by a gap of BASE_INTERVAL*k cycles.
  assign gap      = CW'(BASE_INTERVAL * int'(step_q));
  assign tick_due = (ivl_q + CW'(1)) == gap;
  assign run_done = step_q == KW'(STEPS);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ev)                         state_d = RUN;
        else if (show_ev && cnt_q != '0)      state_d = SHOW;
      end
      RUN: begin
        if (stop_ev || run_done)              state_d = IDLE;
      end
      SHOW: begin
        if (start_ev)                         state_d = RUN;
        else if (stop_ev)                     state_d = IDLE;
      end
      default:                                state_d = IDLE;
    endcase
  end

  // Playback offset is kept below hist_cnt, so it never needs a separate modulo.
  always_comb begin
    p_d = p_q;
    if (!start_ev) begin
      if (state_q == IDLE && show_ev && cnt_q != '0) begin
        p_d = (cnt_q == HW'(1)) ? '0 : PW'(1);
      end else if (state_q == SHOW && stop_ev) begin
        p_d = '0;
      end else if (state_q == SHOW && show_ev) begin
        p_d = ((HW'(p_q) + HW'(1)) == cnt_q) ? '0 : p_q + PW'(1);
      end
    end
  end

  always_comb begin
    int idx;
    idx = int'(wp_q) - 1 - int'(p_d);
    if (idx < 0) idx = idx + DEPTH;
    show_idx = PW'(idx);
  end

  assign hist_rd = hist_q[show_idx];

  always_comb begin
    out_d  = out_q;
    step_d = step_q;
    ivl_d  = ivl_q;
    push   = 1'b0;
    case (state_q)
      IDLE, SHOW: begin
        if (start_ev) begin
          out_d  = sample;
          step_d = KW'(1);
          ivl_d  = '0;
        end else if (state_q == SHOW && stop_ev) begin
          out_d = hist_rd;
        end else if (show_ev && cnt_q != '0) begin
          out_d = hist_rd;
        end
      end
      RUN: begin
        if (stop_ev || run_done) begin
          push = 1'b1;
        end else if (tick_due) begin
          out_d  = sample;
          step_d = step_q + KW'(1);
          ivl_d  = '0;
        end else begin
          ivl_d = ivl_q + CW'(1);
        end
      end
      default: ;
    endcase

    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
      if (cnt_q != HW'(DEPTH)) cnt_d = cnt_q + HW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      show_prev_q  <= 1'b0;
      out_q        <= '0;
      busy_q       <= 1'b0;
      showing_q    <= 1'b0;
      step_q       <= '0;
      ivl_q        <= '0;
      p_q          <= '0;
      wp_q         <= '0;
      cnt_q        <= '0;
    end else begin
      start_prev_q <= i_start;
      stop_prev_q  <= i_stop;
      show_prev_q  <= i_show;
      out_q        <= out_d;
      busy_q       <= (state_d == RUN);
      showing_q    <= (state_d == SHOW);
      step_q       <= step_d;
      ivl_q        <= ivl_d;
      p_q          <= p_d;
      wp_q         <= wp_d;
      cnt_q        <= cnt_d;
      if (push) hist_q[wp_q] <= out_q;
    end
  end

  assign o_random_out = out_q;
  assign o_busy       = busy_q;
  assign o_showing    = showing_q;
  assign o_hist_cnt   = cnt_q;

endmodule

// File: tb/tb_rng_history_core.sv
// tb/tb_rng_history_core.sv - directed self-checking bench for rng_history_core
module tb_rng_history_core;

  localparam int          WIDTH = 4;
  localparam int          DEPTH = 4;
  localparam int          STEPS = 8;
  localparam int          BASE  = 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst, start, stop, show;
  logic [WIDTH-1:0] out;
  logic             busy, showing;
  logic [2:0]       hcnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] a_val, b_val;
  logic [WIDTH-1:0] res [5];
  int               stop_offs [5] = '{3, 5, 7, 13, 21};
  int               show_order [4] = '{3, 2, 1, 4};

  rng_history_core #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STEPS(STEPS), .BASE_INTERVAL(BASE), .SEED(SEED)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_show       (show),
    .o_random_out (out),
    .o_busy       (busy),
    .o_showing    (showing),
    .o_hist_cnt   (hcnt)
  );

  always #5 clk = ~clk;

  // Non-reset edges since the last reset edge = LFSR steps taken so far.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] s;
    s = SEED;
    repeat (n) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
  endfunction

  function automatic int upd_off(input int j);
    return BASE * j * (j - 1) / 2;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge right after the RUN-entry edge; stop_off<0 means no stop press.
  task automatic run_check(input string tag, input int stop_off, input int nchk,
                           output logic [WIDTH-1:0] final_v);
    int               ecyc;
    int               last_u;
    logic [15:0]      lv;
    logic [WIDTH-1:0] expv;
    logic             exp_busy;
    ecyc = cyc - 1;
    expv = '0;
    for (int off = 0; off < nchk; off++) begin
      last_u = 0;
      for (int j = 1; j <= STEPS; j++) begin
        int u;
        u = upd_off(j);
        if (u <= off && (stop_off < 0 || u < stop_off)) last_u = u;
      end
      lv       = lfsr_after(ecyc + last_u);
      expv     = lv[WIDTH-1:0];
      exp_busy = (stop_off < 0) ? (off <= upd_off(STEPS)) : (off < stop_off);
      check({tag, "_out"}, out, expv);
      check({tag, "_busy"}, busy, exp_busy);
      if (off == 1) start = 1'b0;
      if (off == stop_off - 1) stop = 1'b1;
      if (off == stop_off) stop = 1'b0;
      tick;
    end
    final_v = expv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; show = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_showing", showing, 0);
    check("rst_cnt", hcnt, 0);
    rst = 1'b0;
    tick;

    // Full run with start held two cycles.
    start = 1'b1; tick;
    run_check("full", -1, 58, a_val);
    check("full_cnt", hcnt, 1);

    stop = 1'b1; tick; stop = 1'b0;
    check("idle_stop_busy", busy, 0);
    check("idle_stop_out", out, a_val);
    tick;

    show = 1'b1; tick; show = 1'b0;
    check("show1_showing", showing, 1);
    check("show1_out", out, a_val);
    tick;

    // Start from SHOW, stop lands on the update-20 edge.
    start = 1'b1; tick;
    check("show_start_showing", showing, 0);
    run_check("stop20", 20, 120, b_val);
    check("stop20_cnt", hcnt, 2);

    show = 1'b1; tick; show = 1'b0;
    check("show_p1_showing", showing, 1);
    check("show_p1_out", out, a_val);
    tick;
    show = 1'b1; tick; show = 1'b0;
    check("show_wrap_out", out, b_val);
    tick;
    stop = 1'b1; tick; stop = 1'b0;
    check("show_stop_out", out, b_val);
    check("show_stop_showing", showing, 0);
    tick;

    // Five short runs overflow the four-entry ring.
    rst = 1'b1; tick; rst = 1'b0;
    check("rst2_cnt", hcnt, 0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; tick;
      run_check($sformatf("r%0d", i), stop_offs[i], stop_offs[i] + 2, res[i]);
      tick;
    end
    check("ring_cnt", hcnt, 4);
    for (int k = 0; k < 4; k++) begin
      show = 1'b1; tick; show = 1'b0;
      check($sformatf("ring_show%0d", k), out, res[show_order[k]]);
      check($sformatf("ring_showing%0d", k), showing, 1);
      tick;
    end
    stop = 1'b1; tick; stop = 1'b0;
    check("ring_stop_out", out, res[4]);
    tick;

    // Simultaneous keys in IDLE: start wins; show ignored during RUN.
    start = 1'b1; stop = 1'b1; show = 1'b1; tick;
    check("prio_busy", busy, 1);
    check("prio_showing", showing, 0);
    start = 1'b0; stop = 1'b0; show = 1'b0;
    tick; tick;
    show = 1'b1; tick; show = 1'b0;
    check("run_show_showing", showing, 0);
    check("run_show_busy", busy, 1);
    tick; tick;

    // Reset in the middle of the run.
    rst = 1'b1; tick; rst = 1'b0;
    check("midrst_out", out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_showing", showing, 0);
    check("midrst_cnt", hcnt, 0);
    tick;
    show = 1'b1; tick; show = 1'b0;
    check("empty_show_showing", showing, 0);
    check("empty_show_out", out, 0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
